helios_mem_responder: RTL and testbench

- Memory-side responder for the HeliosX core's two memory interfaces: the instruction-fetch port (pc in, two-instruction bundle out) and the data port (address, write enable and write data in, read data out).
- Both ports share one word-organised storage array.
- Adds a preload port, sticky error flags and a store counter.
- Serves as the core's memory in simulation and as the template for the on-chip RAM wrapper.

---
 rtl/helios_mem_responder.sv | 142 ++++++++++++++
 tb/tb_helios_mem_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/helios_mem_responder.sv
// ---------------------------------------------------------------------------
// helios_mem_responder
//
// Memory-side responder for the HeliosX core. One word-organised array is
// shared by the instruction-fetch port, the data load/store port and a
// preload port. Reads on both ports have one cycle of latency and are
// write-first, meaning a same-cycle write to the read word is forwarded.
// Misaligned and out-of-range accesses set sticky error flags. Committed
// stores are counted.
//
// Ports
//   clk_i           clock, all state changes on the rising edge
//   reset_i         asynchronous, active-high reset
//   iaddr_i         fetch byte address (pc)
//   idata_o         fetch bundle {insn @ iaddr+4, insn @ iaddr}
//   dmem_addr_i     data byte address
//   dmem_we_i       store enable
//   dmem_wdata_i    store data
//   dmem_data_o     load data
//   init_we_i       preload write enable
//   init_addr_i     preload byte address
//   init_data_i     preload data
//   err_clr_i       clears both sticky error flags
//   err_misalign_o  sticky, a misaligned access was seen
//   err_range_o     sticky, an out-of-range access was seen
//   store_cnt_o     number of committed stores, wraps modulo 2^32
// ---------------------------------------------------------------------------
module helios_mem_responder #(
    parameter int unsigned           ADDR_LEN = 32,
    parameter int unsigned           DATA_LEN = 32,
    parameter int unsigned           DEPTH    = 4096,
    parameter logic [DATA_LEN-1:0]   PAD_INSN = 32'h00000013
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [ADDR_LEN-1:0]     iaddr_i,
    output logic [2*DATA_LEN-1:0]   idata_o,
    input  logic [ADDR_LEN-1:0]     dmem_addr_i,
    input  logic                    dmem_we_i,
    input  logic [DATA_LEN-1:0]     dmem_wdata_i,
    output logic [DATA_LEN-1:0]     dmem_data_o,
    input  logic                    init_we_i,
    input  logic [ADDR_LEN-1:0]     init_addr_i,
    input  logic [DATA_LEN-1:0]     init_data_i,
    input  logic                    err_clr_i,
    output logic                    err_misalign_o,
    output logic                    err_range_o,
    output logic [31:0]             store_cnt_o
);

    // Word indices carry one extra top bit so that w+1 never overflows and
    // range compares against DEPTH are exact.
    localparam int unsigned W_LEN = ADDR_LEN - 2;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [W_LEN:0] DEPTH_X = (W_LEN+1)'(DEPTH);

    logic [DATA_LEN-1:0] mem [DEPTH];

    logic [W_LEN:0] fetch_wx, fetch_next_wx, dmem_wx, init_wx;
    logic           fetch_in, fetch_next_in, dmem_in, init_in;
    logic           fetch_mis, dmem_mis, init_mis;
    logic           init_ok, dmem_ok;
    logic           misalign_now, range_now;

    logic [DATA_LEN-1:0] ilo_nxt, ihi_nxt, dmem_nxt;

    assign fetch_wx      = {1'b0, iaddr_i[ADDR_LEN-1:2]};
    assign fetch_next_wx = fetch_wx + 1'b1;
    assign dmem_wx       = {1'b0, dmem_addr_i[ADDR_LEN-1:2]};
    assign init_wx       = {1'b0, init_addr_i[ADDR_LEN-1:2]};

    assign fetch_in      = fetch_wx < DEPTH_X;
    assign fetch_next_in = fetch_next_wx < DEPTH_X;
    assign dmem_in       = dmem_wx < DEPTH_X;
    assign init_in       = init_wx < DEPTH_X;

    assign fetch_mis = iaddr_i[1:0] != 2'b00;
    assign dmem_mis  = dmem_addr_i[1:0] != 2'b00;
    assign init_mis  = init_addr_i[1:0] != 2'b00;

    // A preload to the same word takes priority, so the colliding store is
    // dropped entirely and does not count.
    assign init_ok = init_we_i && !init_mis && init_in;
    assign dmem_ok = dmem_we_i && !dmem_mis && dmem_in
                     && !(init_ok && (init_wx == dmem_wx));

    // The fetch range check looks at w only. A bundle whose upper slot falls
    // off the end is padded and is not an error.
    assign misalign_now = fetch_mis || dmem_mis || (init_we_i && init_mis);
    assign range_now    = !fetch_in || !dmem_in || (init_we_i && !init_in);

    // Write-first read of an in-range word. A same-cycle write is forwarded,
    // and init data has priority over store data.
    function automatic logic [DATA_LEN-1:0] read_word(input logic [W_LEN:0] wx);
        if (init_ok && (wx == init_wx))
            return init_data_i;
        else if (dmem_ok && (wx == dmem_wx))
            return dmem_wdata_i;
        else
            return mem[wx[IDX_W-1:0]];
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first, so that no
        // path through the block leaves it unassigned and infers a latch.
        ilo_nxt  = PAD_INSN;
        ihi_nxt  = PAD_INSN;
        dmem_nxt = '0;
        if (fetch_in)      ilo_nxt  = read_word(fetch_wx);
        if (fetch_next_in) ihi_nxt  = read_word(fetch_next_wx);
        if (dmem_in)       dmem_nxt = read_word(dmem_wx);
    end

    // NOTE: the storage array has no reset. Contents survive reset, and a
    // resettable RAM cannot map onto block memory.
    always_ff @(posedge clk_i) begin
        if (init_ok) mem[init_wx[IDX_W-1:0]] <= init_data_i;
        if (dmem_ok) mem[dmem_wx[IDX_W-1:0]] <= dmem_wdata_i;
    end

    // NOTE: sequential state uses non-blocking assignments only, so that
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idata_o        <= '0;
            dmem_data_o    <= '0;
            err_misalign_o <= 1'b0;
            err_range_o    <= 1'b0;
            store_cnt_o    <= '0;
        end else begin
            idata_o     <= {ihi_nxt, ilo_nxt};
            dmem_data_o <= dmem_nxt;
            // A new error in the same cycle as a clear leaves the flag set.
            if (misalign_now)   err_misalign_o <= 1'b1;
            else if (err_clr_i) err_misalign_o <= 1'b0;
            if (range_now)      err_range_o    <= 1'b1;
            else if (err_clr_i) err_range_o    <= 1'b0;
            if (dmem_ok)        store_cnt_o    <= store_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_helios_mem_responder.sv
module tb_helios_mem_responder;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] iaddr_i, dmem_addr_i, dmem_wdata_i, init_addr_i, init_data_i;
    logic        dmem_we_i, init_we_i, err_clr_i;
    logic [63:0] idata_o;
    logic [31:0] dmem_data_o, store_cnt_o;
    logic        err_misalign_o, err_range_o;

    int n_cmp = 0;
    int n_bad = 0;

    helios_mem_responder #(
        .ADDR_LEN(32), .DATA_LEN(32), .DEPTH(4096), .PAD_INSN(32'h00000013)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .iaddr_i(iaddr_i), .idata_o(idata_o),
        .dmem_addr_i(dmem_addr_i), .dmem_we_i(dmem_we_i),
        .dmem_wdata_i(dmem_wdata_i), .dmem_data_o(dmem_data_o),
        .init_we_i(init_we_i), .init_addr_i(init_addr_i), .init_data_i(init_data_i),
        .err_clr_i(err_clr_i), .err_misalign_o(err_misalign_o),
        .err_range_o(err_range_o), .store_cnt_o(store_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // One rising edge, then settle 1 time unit past it before sampling or driving.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        iaddr_i = '0; dmem_addr_i = '0; dmem_we_i = 0; dmem_wdata_i = '0;
        init_we_i = 0; init_addr_i = '0; init_data_i = '0; err_clr_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_i = 1;
        #2;
        n_cmp++; if (idata_o !== 64'h0) begin n_bad++; $display("FAIL reset_idata: got %h want %h", idata_o, 64'h0); end
        n_cmp++; if (dmem_data_o !== 32'h0) begin n_bad++; $display("FAIL reset_dmem: got %h want 0", dmem_data_o); end
        n_cmp++; if (store_cnt_o !== 32'h0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", store_cnt_o); end
        n_cmp++; if ({err_misalign_o, err_range_o} !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b want 00", {err_misalign_o, err_range_o}); end
        step();
        reset_i = 0;
    endtask

    task automatic test_preload();
        init_we_i = 1; init_addr_i = 32'h0; init_data_i = 32'h00500093;
        step();
        init_addr_i = 32'h4; init_data_i = 32'h00A00113;
        step();
        init_we_i = 0; iaddr_i = 32'h0;
        step();
        n_cmp++; if (idata_o !== 64'h00A00113_00500093) begin n_bad++; $display("FAIL preload_fetch: got %h want %h", idata_o, 64'h00A00113_00500093); end
        n_cmp++; if (store_cnt_o !== 32'd0) begin n_bad++; $display("FAIL preload_not_store: got %0d want 0", store_cnt_o); end
    endtask

    task automatic test_store_load();
        dmem_we_i = 1; dmem_addr_i = 32'h40; dmem_wdata_i = 32'hDEADBEEF;
        step();
        dmem_we_i = 0; dmem_addr_i = 32'h0;
        n_cmp++; if (store_cnt_o !== 32'd1) begin n_bad++; $display("FAIL store_cnt1: got %0d want 1", store_cnt_o); end
        step();
        dmem_addr_i = 32'h40;
        step();
        n_cmp++; if (dmem_data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_40: got %h want deadbeef", dmem_data_o); end
    endtask

    task automatic test_same_cycle();
        dmem_we_i = 1; dmem_addr_i = 32'h10; dmem_wdata_i = 32'h1234; iaddr_i = 32'h10;
        step();
        dmem_we_i = 0;
        n_cmp++; if (dmem_data_o !== 32'h1234) begin n_bad++; $display("FAIL wf_dmem: got %h want 1234", dmem_data_o); end
        n_cmp++; if (idata_o[31:0] !== 32'h1234) begin n_bad++; $display("FAIL wf_fetch: got %h want 1234", idata_o[31:0]); end
        n_cmp++; if (store_cnt_o !== 32'd2) begin n_bad++; $display("FAIL store_cnt2: got %0d want 2", store_cnt_o); end
        // Collision: init wins, store dropped and uncounted.
        dmem_we_i = 1; dmem_wdata_i = 32'hAAAA;
        init_we_i = 1; init_addr_i = 32'h10; init_data_i = 32'h55;
        step();
        dmem_we_i = 0; init_we_i = 0;
        n_cmp++; if (dmem_data_o !== 32'h55) begin n_bad++; $display("FAIL coll_dmem: got %h want 55", dmem_data_o); end
        n_cmp++; if (idata_o[31:0] !== 32'h55) begin n_bad++; $display("FAIL coll_fetch: got %h want 55", idata_o[31:0]); end
        n_cmp++; if (store_cnt_o !== 32'd2) begin n_bad++; $display("FAIL coll_cnt: got %0d want 2", store_cnt_o); end
        step();
        n_cmp++; if (dmem_data_o !== 32'h55) begin n_bad++; $display("FAIL coll_kept: got %h want 55", dmem_data_o); end
        // Different words: both written, seen via forwarding on both fetch halves.
        init_we_i = 1; init_addr_i = 32'h20; init_data_i = 32'h77;
        dmem_we_i = 1; dmem_addr_i = 32'h24; dmem_wdata_i = 32'h88; iaddr_i = 32'h20;
        step();
        init_we_i = 0; dmem_we_i = 0;
        n_cmp++; if (idata_o !== {32'h88, 32'h77}) begin n_bad++; $display("FAIL both_fwd: got %h want %h", idata_o, {32'h88, 32'h77}); end
        n_cmp++; if (store_cnt_o !== 32'd3) begin n_bad++; $display("FAIL store_cnt3: got %0d want 3", store_cnt_o); end
        iaddr_i = 32'h0; dmem_addr_i = 32'h24;
        step();
        step();
        n_cmp++; if (dmem_data_o !== 32'h88) begin n_bad++; $display("FAIL both_mem: got %h want 88", dmem_data_o); end
        n_cmp++; if ({err_misalign_o, err_range_o} !== 2'b00) begin n_bad++; $display("FAIL no_err_yet: got %b want 00", {err_misalign_o, err_range_o}); end
    endtask

    task automatic test_boundary();
        init_we_i = 1; init_addr_i = 32'h3FFC; init_data_i = 32'hCAFEF00D; iaddr_i = 32'h3FFC;
        step();
        init_we_i = 0;
        n_cmp++; if (idata_o !== {32'h00000013, 32'hCAFEF00D}) begin n_bad++; $display("FAIL last_word_pad: got %h want %h", idata_o, {32'h00000013, 32'hCAFEF00D}); end
        n_cmp++; if (err_range_o !== 1'b0) begin n_bad++; $display("FAIL last_word_range: got %b want 0", err_range_o); end
        iaddr_i = 32'h0; dmem_addr_i = 32'h4000; dmem_we_i = 1; dmem_wdata_i = 32'h99;
        step();
        dmem_we_i = 0;
        n_cmp++; if (dmem_data_o !== 32'h0) begin n_bad++; $display("FAIL oor_load: got %h want 0", dmem_data_o); end
        n_cmp++; if (err_range_o !== 1'b1) begin n_bad++; $display("FAIL oor_range: got %b want 1", err_range_o); end
        n_cmp++; if (store_cnt_o !== 32'd3) begin n_bad++; $display("FAIL oor_cnt: got %0d want 3", store_cnt_o); end
        dmem_addr_i = 32'h0; iaddr_i = 32'h4000;
        step();
        n_cmp++; if (idata_o !== {32'h13, 32'h13}) begin n_bad++; $display("FAIL oor_fetch: got %h want %h", idata_o, {32'h13, 32'h13}); end
        iaddr_i = 32'h0; err_clr_i = 1;
        step();
        err_clr_i = 0;
        n_cmp++; if (err_range_o !== 1'b0) begin n_bad++; $display("FAIL range_clr: got %b want 0", err_range_o); end
    endtask

    task automatic test_misalign();
        // A misaligned init address without init_we_i must not flag.
        init_addr_i = 32'h3;
        step();
        n_cmp++; if (err_misalign_o !== 1'b0) begin n_bad++; $display("FAIL init_idle_mis: got %b want 0", err_misalign_o); end
        init_addr_i = 32'h0;
        dmem_we_i = 1; dmem_addr_i = 32'h42; dmem_wdata_i = 32'h11111111;
        step();
        dmem_we_i = 0;
        n_cmp++; if (err_misalign_o !== 1'b1) begin n_bad++; $display("FAIL mis_set: got %b want 1", err_misalign_o); end
        n_cmp++; if (store_cnt_o !== 32'd3) begin n_bad++; $display("FAIL mis_cnt: got %0d want 3", store_cnt_o); end
        n_cmp++; if (dmem_data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL mis_unchanged: got %h want deadbeef", dmem_data_o); end
        // Clear while the misaligned address is still present: set wins.
        err_clr_i = 1;
        step();
        n_cmp++; if (err_misalign_o !== 1'b1) begin n_bad++; $display("FAIL set_wins: got %b want 1", err_misalign_o); end
        dmem_addr_i = 32'h40;
        step();
        err_clr_i = 0;
        n_cmp++; if (err_misalign_o !== 1'b0) begin n_bad++; $display("FAIL mis_clr: got %b want 0", err_misalign_o); end
        n_cmp++; if (dmem_data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL reload_40: got %h want deadbeef", dmem_data_o); end
    endtask

    task automatic test_reset_mid();
        dmem_we_i = 1; dmem_addr_i = 32'h80; dmem_wdata_i = 32'hBEEF0001; iaddr_i = 32'h1;
        step();
        dmem_we_i = 0; iaddr_i = 32'h0;
        n_cmp++; if (store_cnt_o !== 32'd4) begin n_bad++; $display("FAIL store_cnt4: got %0d want 4", store_cnt_o); end
        n_cmp++; if (err_misalign_o !== 1'b1) begin n_bad++; $display("FAIL fetch_mis: got %b want 1", err_misalign_o); end
        #2 reset_i = 1;
        #1;
        n_cmp++; if (idata_o !== 64'h0 || dmem_data_o !== 32'h0) begin n_bad++; $display("FAIL mid_reset_data: got %h/%h want 0/0", idata_o, dmem_data_o); end
        n_cmp++; if (store_cnt_o !== 32'd0 || err_misalign_o !== 1'b0) begin n_bad++; $display("FAIL mid_reset_state: got cnt %0d mis %b want 0/0", store_cnt_o, err_misalign_o); end
        reset_i = 0;
        step();
        n_cmp++; if (dmem_data_o !== 32'hBEEF0001) begin n_bad++; $display("FAIL retained: got %h want beef0001", dmem_data_o); end
        n_cmp++; if (idata_o !== 64'h00A00113_00500093) begin n_bad++; $display("FAIL retained_fetch: got %h want %h", idata_o, 64'h00A00113_00500093); end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_store_load();
        test_same_cycle();
        test_boundary();
        test_misalign();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
